// File: rtl/cpu_pkg.sv
// Shared CPU types: word/instruction containers, RAM handshake states and the
// fetch-stage state encoding.
package cpu_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic  valid;
        word_t data;
    } imem_t;

    typedef enum logic [1:0] {
        RAM_FREE,
        RAM_BUSY,
        RAM_ACCESS,
        RAM_ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_REQ,
        F_HOLD,
        F_FLUSH,
        F_ERR
    } fetch_state_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word reads to instruction RAM and buffers one
// fetched instruction for the decoder. Handles redirects and latches fetch faults.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter word_t       RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic      clk,
    input  logic      rst,
    input  ramstate_t ram_state,
    input  word_t     ram_rdata,
    output logic      ram_ren,
    output word_t     ram_addr,
    output imem_t     inst,
    output word_t     inst_pc,
    input  logic      dec_ready,
    input  logic      redirect,
    input  word_t     redirect_pc,
    output logic      fetch_err
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);

    fetch_state_t  state_q, state_d;
    word_t         pc_q, pc_d;
    word_t         addr_q, addr_d;
    word_t         inst_pc_q, inst_pc_d;
    imem_t         inst_q, inst_d;
    logic          ren_q, ren_d;
    logic          err_q, err_d;
    logic [CW-1:0] wd_q, wd_d;

    logic access, ram_fail, bad_tgt, waiting, wd_hit;

    assign access   = (ram_state == RAM_ACCESS);
    assign ram_fail = (ram_state == RAM_ERROR);
    assign bad_tgt  = redirect && (redirect_pc[1:0] != 2'b00);
    assign waiting  = (state_q == F_REQ) || (state_q == F_FLUSH);
    assign wd_hit   = (TIMEOUT_CYC != 0) && waiting && !access && (wd_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= F_IDLE;
        else     state_q <= state_d;
    end

    // RAM errors and watchdog expiry win over redirects; a redirect wins over data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE:  state_d = bad_tgt ? F_ERR : F_REQ;
            F_REQ: begin
                if (ram_fail || bad_tgt || wd_hit) state_d = F_ERR;
                else if (redirect)                 state_d = access ? F_REQ : F_FLUSH;
                else if (access)                   state_d = F_HOLD;
            end
            F_HOLD: begin
                if (bad_tgt)                     state_d = F_ERR;
                else if (redirect || dec_ready)  state_d = F_REQ;
            end
            F_FLUSH: begin
                if (ram_fail || bad_tgt || wd_hit) state_d = F_ERR;
                else if (access)                   state_d = F_IDLE;
            end
            F_ERR:   state_d = F_ERR;
            default: state_d = F_ERR;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        ren_d     = ren_q;
        err_d     = err_q;
        wd_d      = (state_d == state_q && waiting && !access) ? wd_q + CW'(1) : '0;

        if (redirect && state_q != F_ERR) begin
            pc_d         = redirect_pc;
            inst_d.valid = 1'b0;
        end

        case (state_d)
            F_REQ: begin
                // New request on entry, or restart after a redirect swallowed the data.
                if (state_q != F_REQ || access) begin
                    ren_d        = 1'b1;
                    addr_d       = redirect ? redirect_pc : pc_q;
                    inst_d.valid = 1'b0;
                end
            end
            F_HOLD: begin
                if (state_q == F_REQ) begin
                    inst_d    = {1'b1, ram_rdata};
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + 32'd4;
                    ren_d     = 1'b0;
                end
            end
            F_IDLE: ren_d = 1'b0;
            F_ERR: begin
                ren_d        = 1'b0;
                inst_d.valid = 1'b0;
                err_d        = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            ren_q     <= 1'b0;
            err_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            ren_q     <= ren_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
        end
    end

    assign ram_ren   = ren_q;
    assign ram_addr  = addr_q;
    assign inst      = inst_q;
    assign inst_pc   = inst_pc_q;
    assign fetch_err = err_q;

endmodule
